// File: rtl/midi_rx_if.sv
// Output bundle of the MIDI receiver: framed byte strobe, stop-bit error strobe
// and FSM state taps for checkers.
interface midi_rx_if;
  logic       midiByteValid_o;
  logic [7:0] midiByte_o;
  logic       frameErr_o;
  logic [1:0] dbg_rx_state;
  logic [1:0] dbg_parse_state;

  modport master (
    output midiByteValid_o, midiByte_o, frameErr_o, dbg_rx_state, dbg_parse_state
  );
  modport slave (
    input  midiByteValid_o, midiByte_o, frameErr_o, dbg_rx_state, dbg_parse_state
  );
endinterface

// File: rtl/midi_rx.sv
// MIDI 31250-baud UART receiver and Note On/Off framer emitting status/note/velocity strobes.
// Optional running-status reconstruction is enabled by defining MIDI_RUNNING_STATUS_EN.
//
// Output handshake: midiByteValid_o is a one-cycle strobe with no back-pressure;
// midiByte_o is valid whenever midiByteValid_o is 1 and holds its last value otherwise.
module midi_rx #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD        = 31250,
  parameter int OVERSAMPLE  = 16
) (
  input  logic     clk_i,
  input  logic     nrst_i,
  input  logic     rx_i,
  midi_rx_if.master out_if
);

  localparam int DIV = CLK_FREQ_HZ / (BAUD * OVERSAMPLE);
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TW  = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [TW-1:0] HALF_LAST  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST  = TW'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [1:0] {P_WAIT, P_D1, P_D2, P_EMIT} parse_state_t;

  // ---------------- line synchroniser and edge history ----------------
  logic sync1_q, sync2_q, prev_q;

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // ---------------- oversampling prescaler ----------------
  logic [PW-1:0] presc_q;
  logic          tick;
  logic          clr_presc;

  assign tick = (presc_q == PRESC_LAST);

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i)                presc_q <= '0;
    else if (clr_presc || tick) presc_q <= '0;
    else                        presc_q <= presc_q + 1'b1;
  end

  // ---------------- receive FSM ----------------
  rx_state_t     rx_state, rx_next;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          rx_strb;
  logic          frame_err;

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      rx_state <= R_IDLE;
      tcnt_q   <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
    end else begin
      rx_state <= rx_next;
      tcnt_q   <= tcnt_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
    end
  end

  always_comb begin
    rx_next   = rx_state;
    tcnt_d    = tcnt_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    clr_presc = 1'b0;
    rx_strb   = 1'b0;
    frame_err = 1'b0;
    case (rx_state)
      R_IDLE: begin
        if (!sync2_q && prev_q) begin
          rx_next   = R_START;
          clr_presc = 1'b1;
          tcnt_d    = '0;
        end
      end
      R_START: begin
        if (tick) begin
          if (tcnt_q == HALF_LAST) begin
            // Mid start bit: a line already back high was only a glitch.
            rx_next = sync2_q ? R_IDLE : R_DATA;
            tcnt_d  = '0;
            bit_d   = '0;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      R_DATA: begin
        if (tick) begin
          if (tcnt_q == FULL_LAST) begin
            shreg_d = {sync2_q, shreg_q[7:1]};
            tcnt_d  = '0;
            if (bit_q == 3'd7) rx_next = R_STOP;
            else               bit_d   = bit_q + 1'b1;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      R_STOP: begin
        if (tick) begin
          if (tcnt_q == FULL_LAST) begin
            rx_strb   = sync2_q;
            frame_err = !sync2_q;
            rx_next   = R_IDLE;
            tcnt_d    = '0;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      default: rx_next = R_IDLE;
    endcase
  end

  // ---------------- message parser ----------------
  parse_state_t p_state, p_next;
  logic [7:0]   status_q, status_d, note_q, note_d, vel_q, vel_d;
  logic         run_q, run_d;
  logic         emit_q, emit_d;
  logic         valid_q, valid_d;
  logic [7:0]   byte_q, byte_d;
  logic         ferr_q;
  logic         is_data, is_rt, is_note;

  assign is_data = !shreg_q[7];
  assign is_rt   = (shreg_q >= 8'hF8);
  assign is_note = (shreg_q[7:5] == 3'b100);

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      p_state  <= P_WAIT;
      status_q <= '0;
      note_q   <= '0;
      vel_q    <= '0;
      run_q    <= 1'b0;
      emit_q   <= 1'b0;
      valid_q  <= 1'b0;
      byte_q   <= '0;
      ferr_q   <= 1'b0;
    end else begin
      p_state  <= p_next;
      status_q <= status_d;
      note_q   <= note_d;
      vel_q    <= vel_d;
      run_q    <= run_d;
      emit_q   <= emit_d;
      valid_q  <= valid_d;
      byte_q   <= byte_d;
      ferr_q   <= frame_err;
    end
  end

  always_comb begin
    p_next   = p_state;
    status_d = status_q;
    note_d   = note_q;
    vel_d    = vel_q;
    run_d    = run_q;
    emit_d   = emit_q;
    valid_d  = 1'b0;
    byte_d   = byte_q;
    if (p_state == P_EMIT) begin
      // Status went out on entry; these two cycles send note then velocity.
      valid_d = 1'b1;
      byte_d  = emit_q ? vel_q : note_q;
      emit_d  = 1'b1;
      if (emit_q) p_next = P_WAIT;
    end else if (frame_err) begin
      p_next = P_WAIT;
      run_d  = 1'b0;
    end else if (rx_strb && !is_rt) begin
      if (is_note) begin
        status_d = shreg_q;
        run_d    = 1'b1;
        p_next   = P_D1;
      end else if (!is_data) begin
        run_d  = 1'b0;
        p_next = P_WAIT;
      end else begin
        case (p_state)
          P_D1: begin
            note_d = shreg_q;
            p_next = P_D2;
          end
          P_D2: begin
            vel_d   = shreg_q;
            p_next  = P_EMIT;
            emit_d  = 1'b0;
            valid_d = 1'b1;
            byte_d  = status_q;
          end
          default: begin
`ifdef MIDI_RUNNING_STATUS_EN
            if (run_q) begin
              note_d = shreg_q;
              p_next = P_D2;
            end
`endif
          end
        endcase
      end
    end
  end

  // The prescaler must be slow enough that a new byte can never land inside EMIT.
  assert property (@(posedge clk_i) disable iff (!nrst_i) !(rx_strb && p_state == P_EMIT));

  assign out_if.midiByteValid_o = valid_q;
  assign out_if.midiByte_o      = byte_q;
  assign out_if.frameErr_o      = ferr_q;
  assign out_if.dbg_rx_state    = rx_state;
  assign out_if.dbg_parse_state = p_state;

endmodule

// File: tb/tb_midi_rx.sv
// Bench for midi_rx: serial driver, queue-based reference framer, strobe monitor/scoreboard.
// Follows MIDI_RUNNING_STATUS_EN the same way as the design.
module tb_midi_rx;
  localparam int CLK_HZ   = 2_100_000;  // DIV = 4 (truncated from 4.2)
  localparam int DIV      = 4;
  localparam int BIT_CLKS = DIV * 16;
`ifdef MIDI_RUNNING_STATUS_EN
  localparam bit RS_EN = 1'b1;
`else
  localparam bit RS_EN = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic nrst_i;
  logic rx_i;
  midi_rx_if bus ();

  midi_rx #(.CLK_FREQ_HZ(CLK_HZ), .BAUD(31250), .OVERSAMPLE(16)) dut (
    .clk_i  (clk_i),
    .nrst_i (nrst_i),
    .rx_i   (rx_i),
    .out_if (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  logic [7:0] exp_q[$];
  logic [7:0] pend[$];
  logic [7:0] saved_status = 8'h00;
  bit         run_m = 1'b0;
  int         exp_ferr = 0;

  task automatic model_byte(input logic [7:0] b, input bit ok);
    if (!ok) begin
      exp_ferr++;
      pend.delete();
      run_m = 1'b0;
    end else if (b >= 8'hF8) begin
      // realtime: invisible
    end else if (b >= 8'h80 && b <= 8'h9F) begin
      pend.delete();
      pend.push_back(b);
      saved_status = b;
      run_m = 1'b1;
    end else if (b >= 8'hA0) begin
      pend.delete();
      run_m = 1'b0;
    end else if (pend.size() == 0) begin
      if (run_m && RS_EN) begin
        pend.push_back(saved_status);
        pend.push_back(b);
      end
    end else begin
      pend.push_back(b);
      if (pend.size() == 3) begin
        for (int i = 0; i < 3; i++) exp_q.push_back(pend[i]);
        pend.delete();
      end
    end
  endtask

  task automatic model_reset();
    pend.delete();
    run_m = 1'b0;
  endtask

  // ---------------- driver ----------------
  task automatic idle_bits(input int n);
    rx_i = 1'b1;
    repeat (n * BIT_CLKS) @(negedge clk_i);
  endtask

  // rst_bit >= 0 asserts reset at that bit and holds it to the end of the frame.
  task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int rst_bit);
    for (int i = 0; i < 10; i++) begin
      if (i == 0)      rx_i = 1'b0;
      else if (i == 9) rx_i = stop_ok;
      else             rx_i = b[i-1];
      if (i == rst_bit) begin
        nrst_i = 1'b0;
        model_reset();
      end
      if (i == 9 && rst_bit < 0) model_byte(b, stop_ok);
      repeat (BIT_CLKS) @(negedge clk_i);
    end
    rx_i = 1'b1;
    if (rst_bit >= 0) begin
      repeat (4) @(negedge clk_i);
      nrst_i = 1'b1;
    end
    if (!stop_ok) idle_bits(1);
  endtask

  task automatic send_ok(input logic [7:0] b);
    send_byte(b, 1'b1, -1);
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [7:0] last_byte = 8'h00;
  logic [7:0] exp_b;
  int  run_len = 0;
  int  ferr_seen = 0;
  bit  prev_ferr = 1'b0;

  always @(negedge clk_i) begin
    if (!nrst_i) begin
      n_checks++;
      if (bus.midiByteValid_o !== 1'b0 || bus.midiByte_o !== 8'h00 || bus.frameErr_o !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_outputs: valid=%b byte=%h ferr=%b, required 0/00/0",
                 bus.midiByteValid_o, bus.midiByte_o, bus.frameErr_o);
      end
      run_len   = 0;
      last_byte = 8'h00;
    end else begin
      if (bus.midiByteValid_o === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_strobe: got %h, required no strobe", bus.midiByte_o);
        end else begin
          exp_b = exp_q.pop_front();
          if (bus.midiByte_o !== exp_b) begin
            n_fail++;
            $display("FAIL strobe_byte: got %h, required %h", bus.midiByte_o, exp_b);
          end
        end
        run_len++;
        last_byte = bus.midiByte_o;
      end else begin
        if (run_len != 0) begin
          n_checks++;
          if (run_len != 3) begin
            n_fail++;
            $display("FAIL burst_length: got %0d back-to-back strobes, required 3", run_len);
          end
          run_len = 0;
        end
        n_checks++;
        if (bus.midiByte_o !== last_byte) begin
          n_fail++;
          $display("FAIL byte_hold: got %h, required %h", bus.midiByte_o, last_byte);
        end
      end
      if (bus.frameErr_o === 1'b1) begin
        ferr_seen++;
        n_checks++;
        if (prev_ferr) begin
          n_fail++;
          $display("FAIL frame_err_width: got 2+ cycle pulse, required 1 cycle");
        end
      end
    end
    prev_ferr = bus.frameErr_o;
  end

  // ---------------- watchdog ----------------
  initial begin
    repeat (95000) @(posedge clk_i);
    $display("FAIL watchdog: stimulus still running after 95000 cycles, required completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] b;
    int         r;
    nrst_i = 1'b0;
    rx_i   = 1'b1;
    repeat (10) @(negedge clk_i);
    nrst_i = 1'b1;
    idle_bits(2);

    // Basic Note On
    send_ok(8'h90); send_ok(8'h3C); send_ok(8'h64);
    idle_bits(2);
    // Realtime byte inside a message
    send_ok(8'h90); send_ok(8'h3C); send_ok(8'hF8); send_ok(8'h64);
    idle_bits(2);
    // Running status
    send_ok(8'h80); send_ok(8'h40); send_ok(8'h00); send_ok(8'h41); send_ok(8'h00);
    idle_bits(2);
    // Stop-bit error on the status byte
    send_byte(8'h90, 1'b0, -1); send_ok(8'h3C); send_ok(8'h64);
    idle_bits(2);
    // Other status (control change) is dropped
    send_ok(8'hB0); send_ok(8'h07); send_ok(8'h7F);
    idle_bits(2);
    // Short low glitch on the idle line
    rx_i = 1'b0;
    repeat (4 * DIV) @(negedge clk_i);
    idle_bits(3);
    // Reset during the velocity byte, then orphan data bytes
    send_ok(8'h90); send_ok(8'h3C); send_byte(8'h64, 1'b1, 4);
    idle_bits(2);
    send_ok(8'h3C); send_ok(8'h64);
    idle_bits(2);

    // Randomized byte stream
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 99);
      if (r < 20)      b = 8'h80 | 8'($urandom_range(0, 31));
      else if (r < 65) b = 8'($urandom_range(0, 127));
      else if (r < 75) b = 8'($urandom_range(248, 255));
      else if (r < 85) b = 8'($urandom_range(160, 247));
      else             b = 8'($urandom_range(0, 127));
      send_byte(b, ($urandom_range(0, 19) != 0), -1);
      if ($urandom_range(0, 1) != 0) idle_bits(1);
    end

    idle_bits(4);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected strobes never seen, required 0", exp_q.size());
    end
    n_checks++;
    if (ferr_seen != exp_ferr) begin
      n_fail++;
      $display("FAIL frame_err_count: got %0d pulses, required %0d", ferr_seen, exp_ferr);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
